// File: rtl/ui_uart_pkg.sv
// Shared UART-side definitions: ASCII control characters and the
// LF expansion state encoding used by ui_tx_char_fifo.
package ui_uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // S_NORM: pass head through (or emit CR in front of an LF head).
  // S_LF:   CR already sent, now presenting the LF itself.
  typedef enum logic [0:0] {
    S_NORM = 1'b0,
    S_LF   = 1'b1
  } xstate_e;

endpackage

// File: rtl/ui_char_ram.sv
// DEPTH x 8 character storage: synchronous write, asynchronous read.
// No reset on the array; occupancy is tracked by the owner.
module ui_char_ram #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Write port: one character per cycle when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: head entry is visible in the same cycle the pointer moves.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/ui_tx_char_fifo.sv
// Character FIFO feeding the UART transmitter. Characters are popped only
// on tx_done; fill level and a sticky overflow flag go back to the producer.
// Optional LF -> CR+LF expansion is compiled in with UI_TX_LF_EXPAND_EN.
module ui_tx_char_fifo
  import ui_uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             wr_full,
  output logic [CNT_W-1:0] fill_cnt,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic             tx_data_val,
  output logic [7:0]       tx_data,
  input  logic             tx_done
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic       not_empty;
  logic       wr_acc;
  logic       pop;
  logic       lf_hold;
  logic [7:0] head;
  logic [7:0] present;

  ui_char_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

`ifdef UI_TX_LF_EXPAND_EN
  xstate_e state_q, state_d;

  // Expansion: an LF head is first shown as CR without popping, then as LF.
  always_comb begin
    state_d = state_q;
    present = head;
    lf_hold = 1'b0;
    unique case (state_q)
      S_NORM: begin
        if (not_empty && (head == ASCII_LF)) begin
          present = ASCII_CR;
          lf_hold = 1'b1;
          if (tx_done) begin
            state_d = S_LF;
          end
        end
      end
      S_LF: begin
        // Only a pop leaves the head, so the LF is still present here.
        if (tx_done) begin
          state_d = S_NORM;
        end
      end
      default: state_d = S_NORM;
    endcase
  end

  // Expansion state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_NORM;
    end else begin
      state_q <= state_d;
    end
  end
`else
  // No expansion: head passes straight through and every tx_done may pop.
  always_comb begin
    present = head;
    lf_hold = 1'b0;
  end
`endif

  // Handshake decode and next-state for pointers, count and overflow flag.
  always_comb begin
    not_empty = (cnt_q != '0);
    wr_full   = (cnt_q == CntFull);
    // Full is judged on the start-of-cycle count, even if a pop coincides.
    wr_acc    = wr_en && !wr_full;
    pop       = tx_done && not_empty && !lf_hold;

    wr_ptr_d = wr_acc ? (wr_ptr_q + PtrOne) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PtrOne) : rd_ptr_q;

    cnt_d = cnt_q;
    case ({wr_acc, pop})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase

    // Set has priority over clear so a coincident drop is never lost.
    if (wr_en && wr_full) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO state registers; reset empties the FIFO immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Outputs; tx_data is forced to zero when nothing is stored.
  always_comb begin
    fill_cnt    = cnt_q;
    ovf         = ovf_q;
    tx_data_val = not_empty;
    tx_data     = not_empty ? present : 8'h00;
  end

endmodule

// File: tb/tb_ui_tx_char_fifo.sv
// Scoreboard bench for ui_tx_char_fifo. Define UI_TX_LF_EXPAND_EN for both
// bench and RTL to exercise the CR insertion build.
module tb_ui_tx_char_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [7:0]       wr_data = 8'h00;
  logic             wr_full;
  logic [CNT_W-1:0] fill_cnt;
  logic             ovf;
  logic             ovf_clr = 1'b0;
  logic             tx_data_val;
  logic [7:0]       tx_data;
  logic             tx_done = 1'b0;

  int total = 0;
  int bad   = 0;

  // Reference model: stored characters, characters still to be transmitted.
  logic [7:0] m_store[$];
  logic [7:0] m_exp[$];
  bit         m_ovf = 1'b0;
  bit         m_cr_sent = 1'b0;

  ui_tx_char_fifo #(
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_full     (wr_full),
    .fill_cnt    (fill_cnt),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr),
    .tx_data_val (tx_data_val),
    .tx_data     (tx_data),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each active edge, cleared by asynchronous reset.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_store.delete();
      m_exp.delete();
      m_ovf = 1'b0;
      m_cr_sent = 1'b0;
    end else begin
      int  n;
      bit  acc;
      n   = m_store.size();
      acc = wr_en && (n < DEPTH);
      if (tx_done && n > 0) begin
`ifdef UI_TX_LF_EXPAND_EN
        if (m_store[0] == 8'h0A && !m_cr_sent) begin
          m_cr_sent = 1'b1;
        end else begin
          void'(m_store.pop_front());
          m_cr_sent = 1'b0;
        end
`else
        void'(m_store.pop_front());
`endif
      end
      if (acc) begin
        m_store.push_back(wr_data);
`ifdef UI_TX_LF_EXPAND_EN
        if (wr_data == 8'h0A) m_exp.push_back(8'h0D);
`endif
        m_exp.push_back(wr_data);
      end
      if (wr_en && !acc) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  end

  // Monitor: status against model, presented character against scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("fill_cnt", int'(fill_cnt), m_store.size());
      chk("tx_data_val", int'(tx_data_val), int'(m_store.size() != 0));
      chk("wr_full", int'(wr_full), int'(m_store.size() == DEPTH));
      chk("ovf", int'(ovf), int'(m_ovf));
      if (tx_data_val) begin
        if (m_exp.size() == 0) begin
          chk("sb_underrun", 1, 0);
        end else begin
          chk("tx_data", int'(tx_data), int'(m_exp[0]));
          if (tx_done) void'(m_exp.pop_front());
        end
      end
    end
  end

  // One cycle of stimulus, applied just after an edge and held to the next.
  task automatic step(input bit we, input logic [7:0] wd, input bit td, input bit oc);
    wr_en   = we;
    wr_data = wd;
    tx_done = td;
    ovf_clr = oc;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    tx_done = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic drain();
    repeat (2 * DEPTH + 2) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_val", int'(tx_data_val), 0);
    chk("rst_data", int'(tx_data), 0);
    chk("rst_cnt", int'(fill_cnt), 0);
    chk("rst_full", int'(wr_full), 0);
    chk("rst_ovf", int'(ovf), 0);

    // Basic transfer
    step(1'b1, 8'h41, 1'b0, 1'b0);
    chk("val_after_wr", int'(tx_data_val), 1);
    chk("first_data", int'(tx_data), 8'h41);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b0);
    chk("cnt3", int'(fill_cnt), 3);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("head_held", int'(tx_data), 8'h41);
    drain();
    chk("drained", int'(fill_cnt), 0);

    // Full and overflow
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    chk("full_flag", int'(wr_full), 1);
    chk("full_cnt", int'(fill_cnt), DEPTH);
    chk("ovf_set", int'(ovf), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", int'(ovf), 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("full_drop", int'(wr_full), 0);
    drain();

    // Simultaneous write and pop at count 1
    step(1'b1, 8'h20, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("simul_cnt", int'(fill_cnt), 1);
    chk("simul_head", int'(tx_data), 8'h55);
    drain();

    // Pointer wrap, interleaved
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    drain();

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_val", int'(tx_data_val), 0);
    chk("arst_cnt", int'(fill_cnt), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 8'h30, 1'b0, 1'b0);
    chk("post_rst_head", int'(tx_data), 8'h30);
    drain();

    // LF handling
    step(1'b1, 8'h61, 1'b0, 1'b0);
    step(1'b1, 8'h0A, 1'b0, 1'b0);
    chk("lf_a", int'(tx_data), 8'h61);
    step(1'b0, 8'h00, 1'b1, 1'b0);
`ifdef UI_TX_LF_EXPAND_EN
    chk("lf_cr", int'(tx_data), 8'h0D);
    chk("lf_cnt_cr", int'(fill_cnt), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("lf_lf", int'(tx_data), 8'h0A);
    chk("lf_cnt_lf", int'(fill_cnt), 1);
`else
    chk("lf_lf", int'(tx_data), 8'h0A);
    chk("lf_cnt_lf", int'(fill_cnt), 1);
`endif
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("lf_done", int'(fill_cnt), 0);

    // Randomized traffic alternating fill-heavy and drain-heavy phases
    for (int i = 0; i < 1200; i++) begin
      int unsigned wp;
      logic [7:0]  d;
      wp = ((i / 150) % 2 == 0) ? 75 : 30;
      d  = ($urandom_range(0, 4) == 0) ? 8'h0A : 8'($urandom);
      step($urandom_range(0, 99) < wp, d, $urandom_range(0, 99) < (100 - wp),
           $urandom_range(0, 19) == 0);
    end
    drain();
    chk("sb_empty", m_exp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ui_tx_char_fifo.md
# ui_tx_char_fifo

Character FIFO that sits directly upstream of the UART transmitter: it buffers ASCII characters written by the UI response logic and presents them one at a time on the transmitter's `tx_data_val`/`tx_data`/`tx_done` handshake. A character is popped only when the transmitter signals completion with `tx_done`. Fill level and a sticky overflow flag are exported for the producer. An optional LF→CR+LF expansion is compiled in by macro.

## Interface
- `DEPTH`, 16: storage depth in characters; power of two, ≥ 2.
- `CNT_W`, `$clog2(DEPTH)+1`: width of the fill count (localparam).

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `wr_en`  in  1  write strobe from the producer
- `wr_data`  in  8  character to write
- `wr_full`  out  1  FIFO full; writes in this cycle are dropped
- `fill_cnt`  out  CNT_W  number of stored characters, 0..DEPTH
- `ovf`  out  1  sticky flag: a write was dropped
- `ovf_clr`  in  1  clears `ovf`
- `tx_data_val`  out  1  character available to the transmitter
- `tx_data`  out  8  character presented to the transmitter
- `tx_done`  in  1  single-cycle pop pulse from the transmitter

## Operation
- Storage is `DEPTH` × 8 bits with `rd_ptr`/`wr_ptr` of `$clog2(DEPTH)` bits. Both pointers wrap modulo `DEPTH`. Full/empty are derived from `fill_cnt`.
- Write: `wr_en && !wr_full` stores `wr_data` at `wr_ptr` and increments `wr_ptr`.
- Overflow: `wr_en && wr_full` drops the data and sets `ovf`. This applies even if `tx_done` pops in the same cycle, because `wr_full` reflects the start-of-cycle count.
- Overflow flag: `ovf_clr` clears `ovf`. If set and clear coincide, set wins.
- Read: `tx_data_val = (fill_cnt != 0)`. `tx_data` is the head entry, read combinationally from storage. Head and valid are held stable until `tx_done`.
- Pop: `tx_done && tx_data_val` increments `rd_ptr`. `tx_done` while `tx_data_val` is low is ignored.
- Fill count: a simultaneous accepted write and pop leaves `fill_cnt` unchanged. A write alone adds 1; a pop alone subtracts 1.
- Overflow in the count is impossible. Underflow is prevented by the pop gating above.

## Timing
- Reset values: `wr_full`=0, `fill_cnt`=0, `ovf`=0, `tx_data_val`=0, `tx_data`=0x00, both pointers 0, expansion state `S_NORM`.
- Reset asserted mid-transfer empties the FIFO immediately (asynchronous). The in-flight character is lost.
- Write latency: a write accepted at edge k makes `tx_data_val`=1 and `tx_data`=data in the cycle after edge k.
- Pop latency: after a `tx_done` at edge k, the next head (or `tx_data_val`=0) appears in the cycle after edge k.
- Full: `wr_full` updates in the cycle after the edge that makes `fill_cnt`==DEPTH. It drops in the cycle after the first pop from full.
- Throughput: one write and one pop per cycle, sustained.

## Configuration
- Macro `UI_TX_LF_EXPAND_EN`: compiles in CR insertion.
  - When defined, a 2-state FSM runs:
    - `S_NORM` with head == 0x0A: present `tx_data`=0x0D and do not pop on `tx_done`; go to `S_LF`.
    - `S_LF`: present head (0x0A); `tx_done` pops and returns to `S_NORM`.
    - Any other head character passes through unchanged in `S_NORM`.
  - When undefined, there is no FSM and the FIFO contents pass through unchanged. `fill_cnt` counts stored characters only in both builds.

## Structure
- Shared package `ui_uart_pkg`:
  - `ASCII_CR` (8'h0D) and `ASCII_LF` (8'h0A).
  - Expansion state enum `{S_NORM, S_LF}`.
- Natural sub-module `ui_char_ram`: `DEPTH`×8 storage with synchronous write and asynchronous read. Pointer, count, flag and FSM logic stay in the top.

## Test plan
- Basic transfer: after reset, write 0x41, 0x42, 0x43 on consecutive cycles.
  - `tx_data_val`=1 the cycle after the first write.
  - `tx_data` reads 0x41, 0x42, 0x43, each held until its `tx_done` pulse.
  - `fill_cnt` goes 1→2→3→…→0.
- Full and overflow (DEPTH=16): write 17 characters with no pops.
  - `wr_full`=1 and `fill_cnt`=16; the 17th character is dropped and `ovf`=1.
  - `ovf_clr` returns `ovf` to 0.
  - One `tx_done` drops `wr_full` the next cycle.
- Simultaneous write/pop at `fill_cnt`=1: write 0x55 while `tx_done` pulses.
  - `fill_cnt` stays 1 and the head becomes 0x55.
- Pointer wrap: write and pop 40 characters 0x00..0x27 interleaved.
  - The output sequence exactly matches the input order across pointer wrap.
- Reset mid-operation: load 5 characters and assert `rst_n`=0 asynchronously mid-cycle.
  - `tx_data_val`=0 and `fill_cnt`=0 immediately.
  - After release, a new write of 0x30 is output first.
- With `UI_TX_LF_EXPAND_EN` defined: write 0x61, 0x0A.
  - Transmitted sequence is 0x61, 0x0D, 0x0A.
  - `fill_cnt` decrements only after the 0x0A `tx_done`.
  - Without the macro, the sequence is 0x61, 0x0A.
